// File: rtl/bit_serial_pkg.sv
// Shared types and helpers for the bit-serial subtract unit.
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the bit counter needed to count 0..width-1.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow out.
// Counterpart of the adder cells; usable on its own.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow for one bit position.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: d = (a - b) mod 2^WIDTH, LSB first,
// one bit per clock through a single full-subtractor cell.
//
// state | meaning
// IDLE  | waiting for start; d/bout hold the last result
// RUN   | one bit processed per edge, WIDTH edges total
// DONE  | one-cycle done pulse; start here chains the next operation
module bit_serial_subtractor
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             di;
    logic             bnext;
    logic             accept;
    logic             last_bit;

    full_subtractor u_fs (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (br),
        .d    (di),
        .bout (bnext)
    );

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == RUN) && (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; start is ignored while RUN.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_bit) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand shift registers, borrow flop, bit counter and result shadow.
    // d/bout load only on the final bit so they hold through a new start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            res  <= '0;
            cnt  <= '0;
            br   <= 1'b0;
            d    <= '0;
            bout <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            br  <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= {di, res[WIDTH-1:1]};
            br  <= bnext;
            cnt <= cnt + 1'b1;
            if (last_bit) begin
                d    <= {di, res[WIDTH-1:1]};
                bout <= bnext;
            end
        end
    end

    // Status outputs decoded straight from the state register.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench: directed table, hand-written corner sequences and
// randomized operations at WIDTH=8 and WIDTH=2 against a plain arithmetic model.
module tb_bit_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start8, busy8, done8, bout8;
    logic [7:0] a8, b8, d8;
    logic       start2, busy2, done2, bout2;
    logic [1:0] a2, b2, d2;

    int total = 0;
    int bad   = 0;

    int          sel = 8;
    logic        cur_busy, cur_done, cur_bout;
    logic [31:0] cur_d;
    logic [31:0] last_d8 = 0, last_d2 = 0;
    logic        last_b8 = 0, last_b2 = 0;

    bit_serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8)
    );

    bit_serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .d(d2), .bout(bout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cur_busy = (sel == 8) ? busy8 : busy2;
    assign cur_done = (sel == 8) ? done8 : done2;
    assign cur_bout = (sel == 8) ? bout8 : bout2;
    assign cur_d    = (sel == 8) ? {24'd0, d8} : {30'd0, d2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation; expectations come from plain modular arithmetic.
    task automatic do_op(input int w, input logic [31:0] av, input logic [31:0] bv, input string tag);
        logic [31:0] mask;
        logic [31:0] am, bm, exp_d, held_d;
        logic        exp_b, held_b;
        int          lat;
        bit          seen;
        bit          busy_err;
        sel    = w;
        mask   = (32'd1 << w) - 32'd1;
        am     = av & mask;
        bm     = bv & mask;
        exp_d  = (am - bm) & mask;
        exp_b  = (am < bm);
        held_d = (w == 8) ? last_d8 : last_d2;
        held_b = (w == 8) ? last_b8 : last_b2;
        if (w == 8) begin
            start8 = 1'b1; a8 = am[7:0]; b8 = bm[7:0];
        end else begin
            start2 = 1'b1; a2 = am[1:0]; b2 = bm[1:0];
        end
        tick();
        start8 = 1'b0; start2 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        a2 = 2'($urandom); b2 = 2'($urandom);
        lat = 0; seen = 0; busy_err = 0;
        while (lat < 40) begin
            if (cur_done) begin
                seen = 1;
                break;
            end
            if (cur_busy !== 1'b1) busy_err = 1;
            if (lat == 0) begin
                chk({tag, " held_d"}, cur_d, held_d);
                chk({tag, " held_bout"}, {31'd0, cur_bout}, {31'd0, held_b});
            end
            tick();
            lat++;
        end
        chk({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            chk({tag, " latency"}, lat, w);
            chk({tag, " busy_during_run"}, {31'd0, busy_err}, 32'd0);
            chk({tag, " busy_with_done"}, {31'd0, cur_busy}, 32'd0);
            chk({tag, " d"}, cur_d, exp_d);
            chk({tag, " bout"}, {31'd0, cur_bout}, {31'd0, exp_b});
            tick();
            chk({tag, " done_one_cycle"}, {31'd0, cur_done}, 32'd0);
            chk({tag, " d_hold"}, cur_d, exp_d);
        end
        if (w == 8) begin
            last_d8 = exp_d; last_b8 = exp_b;
        end else begin
            last_d2 = exp_d; last_b2 = exp_b;
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vt[7];

    initial begin
        int          dones;
        logic [31:0] got_d;
        logic        got_b;
        logic [7:0]  qa[$];
        logic [7:0]  qb[$];
        int          captured;
        int          prev_done;
        logic [7:0]  ea, eb;

        vt[0] = '{a: 8'd5,   b: 8'd3,   d: 8'd2,   bo: 1'b0};
        vt[1] = '{a: 8'd3,   b: 8'd5,   d: 8'd254, bo: 1'b1};
        vt[2] = '{a: 8'd0,   b: 8'd1,   d: 8'd255, bo: 1'b1};
        vt[3] = '{a: 8'd255, b: 8'd255, d: 8'd0,   bo: 1'b0};
        vt[4] = '{a: 8'd0,   b: 8'd0,   d: 8'd0,   bo: 1'b0};
        vt[5] = '{a: 8'd128, b: 8'd1,   d: 8'd127, bo: 1'b0};
        vt[6] = '{a: 8'd1,   b: 8'd128, d: 8'd129, bo: 1'b1};

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        #17;
        chk("reset busy8", {31'd0, busy8}, 32'd0);
        chk("reset done8", {31'd0, done8}, 32'd0);
        chk("reset d8", {24'd0, d8}, 32'd0);
        chk("reset bout8", {31'd0, bout8}, 32'd0);
        chk("reset busy2", {31'd0, busy2}, 32'd0);
        chk("reset d2", {30'd0, d2}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle busy8", {31'd0, busy8}, 32'd0);
        chk("idle done8", {31'd0, done8}, 32'd0);

        // Directed table at WIDTH=8 with hand-computed results.
        for (int i = 0; i < 7; i++) begin
            do_op(8, {24'd0, vt[i].a}, {24'd0, vt[i].b}, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d table_d", i), {24'd0, d8}, {24'd0, vt[i].d});
            chk($sformatf("vec%0d table_bout", i), {31'd0, bout8}, {31'd0, vt[i].bo});
        end

        // Start pulsed mid-RUN with other operands must be ignored.
        sel = 8;
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd100;
        tick();
        start8 = 1'b0;
        dones = 0; got_d = 0; got_b = 0;
        for (int c = 1; c < 30; c++) begin
            if (c == 3) begin
                start8 = 1'b1; a8 = 8'd1; b8 = 8'd2;
            end else begin
                start8 = 1'b0;
            end
            tick();
            if (done8) begin
                dones++;
                got_d = {24'd0, d8};
                got_b = bout8;
            end
        end
        chk("midrun done_count", dones, 1);
        chk("midrun d", got_d, 32'd100);
        chk("midrun bout", {31'd0, got_b}, 32'd0);
        last_d8 = 32'd100; last_b8 = 1'b0;

        // Start held high: operations chain through DONE with no IDLE cycle.
        start8 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom);
        qa.push_back(a8); qb.push_back(b8);
        captured = 1;
        tick();
        a8 = 8'($urandom); b8 = 8'($urandom);
        prev_done = -1;
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            if (done8) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("chain d", {24'd0, d8}, {24'd0, ea - eb});
                chk("chain bout", {31'd0, bout8}, {31'd0, (ea < eb)});
                chk("chain gap", c - prev_done, (prev_done < 0) ? c + 1 : 9);
                prev_done = c;
                dones++;
                last_d8 = {24'd0, ea - eb}; last_b8 = (ea < eb);
                if (captured < 4) begin
                    qa.push_back(a8); qb.push_back(b8);
                    captured++;
                end else begin
                    start8 = 1'b0;
                end
            end else if (prev_done >= 0 && c == prev_done + 1 && start8) begin
                chk("chain busy_no_idle", {31'd0, busy8}, 32'd1);
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
            tick();
        end
        start8 = 1'b0;
        chk("chain done_count", dones, 4);

        // Asynchronous reset in the middle of RUN discards the operation.
        do_op(8, 32'd200, 32'd50, "pre_reset");
        start8 = 1'b1; a8 = 8'd10; b8 = 8'd3;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async busy", {31'd0, busy8}, 32'd0);
        chk("async done", {31'd0, done8}, 32'd0);
        chk("async d", {24'd0, d8}, 32'd0);
        chk("async bout", {31'd0, bout8}, 32'd0);
        dones = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done8) dones++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done8) dones++;
        end
        chk("async no_done", dones, 0);
        last_d8 = 0; last_b8 = 0; last_d2 = 0; last_b2 = 0;
        do_op(8, 32'd10, 32'd3, "post_reset");

        // Randomized operations at both widths.
        for (int i = 0; i < 1000; i++)
            do_op(8, $urandom_range(0, 255), $urandom_range(0, 255), "rnd8");
        for (int i = 0; i < 1000; i++)
            do_op(2, $urandom_range(0, 3), $urandom_range(0, 3), "rnd2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
